vec_result_writer: RTL and testbench

VEC_RESULT_WRITER -- requirements
Module: vec_result_writer

---
 rtl/vec_result_writer.sv | 180 ++++++++++++++++++
 tb/tb_vec_result_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_result_writer.sv
// Buffers up to two vector-ALU result bundles and streams them word by word into data memory.
// Optional macro VWB_ADD_LANES_EN: also stores and writes the four add lanes (16 words per bundle instead of 12).
module vec_result_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          BCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vec_alu_op,
  input  logic [255:0]      res_mul,
  input  logic [127:0]      res_sum,
  input  logic [127:0]      res_add,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              overflow,
  output logic [BCNT_W-1:0] bundle_cnt
);

`ifdef VWB_ADD_LANES_EN
  localparam logic [3:0]  LAST_IDX = 4'd15;
  localparam logic [31:0] WORDS    = 32'd16;
`else
  localparam logic [3:0]  LAST_IDX = 4'd11;
  localparam logic [31:0] WORDS    = 32'd12;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         occ_q, occ_d;
  logic               wr_ptr_q, rd_ptr_q;
  logic [3:0]         word_idx_q, word_idx_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               ovf_q, ovf_d;

  logic [255:0]       mul_q [2];
  logic [127:0]       sum_q [2];
`ifdef VWB_ADD_LANES_EN
  logic [127:0]       add_q [2];
`else
  logic               unused_add_s;
  assign unused_add_s = ^res_add;
`endif

  logic               push_s;
  logic               pop_s;
  logic [31:0]        word_s;
  logic [31:0]        word_off_s;

  assign in_ready   = (occ_q < 2'd2);
  assign push_s     = vec_alu_op & in_ready;
  assign mem_we     = (state_q == SEND);
  assign pop_s      = mem_we & mem_ready & (word_idx_q == LAST_IDX);
  assign done       = pop_s;
  assign overflow   = ovf_q;
  assign bundle_cnt = bcnt_q;

  // Next-state logic for the stream FSM, occupancy, word index and counters
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    word_idx_d = word_idx_q;
    bcnt_d     = bcnt_q;
    ovf_d      = ovf_q;

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (vec_alu_op && !in_ready) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    case (state_q)
      IDLE: begin
        if (push_s) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (mem_ready) begin
          if (word_idx_q == LAST_IDX) begin
            word_idx_d = 4'd0;
            bcnt_d     = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
            // A push in the same cycle keeps occupancy nonzero, so streaming continues without a bubble
            if (occ_d == 2'd0) begin
              state_d = IDLE;
            end else begin
              state_d = SEND;
            end
          end else begin
            word_idx_d = word_idx_q + 4'd1;
            state_d    = SEND;
          end
        end else begin
          word_idx_d = word_idx_q;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      word_idx_q <= 4'd0;
      bcnt_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      word_idx_q <= word_idx_d;
      bcnt_q     <= bcnt_d;
      ovf_q      <= ovf_d;
      if (push_s) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Bundle storage, all lanes captured together on push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mul_q[i] <= 256'h0;
        sum_q[i] <= 128'h0;
`ifdef VWB_ADD_LANES_EN
        add_q[i] <= 128'h0;
`endif
      end
    end else if (push_s) begin
      mul_q[wr_ptr_q] <= res_mul;
      sum_q[wr_ptr_q] <= res_sum;
`ifdef VWB_ADD_LANES_EN
      add_q[wr_ptr_q] <= res_add;
`endif
    end
  end

  // Select the current word of the head entry
  always_comb begin
    word_s = 32'h0;
    case (word_idx_q[3:2])
      2'b00, 2'b01: word_s = mul_q[rd_ptr_q][{word_idx_q[2:0], 5'b00000} +: 32];
      2'b10:        word_s = sum_q[rd_ptr_q][{word_idx_q[1:0], 5'b00000} +: 32];
`ifdef VWB_ADD_LANES_EN
      2'b11:        word_s = add_q[rd_ptr_q][{word_idx_q[1:0], 5'b00000} +: 32];
`else
      2'b11:        word_s = 32'h0;
`endif
      default:      word_s = 32'h0;
    endcase
  end

  assign word_off_s = 32'(bcnt_q) * WORDS + {28'h0, word_idx_q};
  assign mem_addr   = BASE_ADDR + {word_off_s[29:0], 2'b00};
  assign mem_wdata  = mem_we ? word_s : 32'h0;

endmodule

// File: tb/tb_vec_result_writer.sv
// Scoreboard bench for vec_result_writer: stimulus pushes expected words, a negedge monitor checks each transfer.
module tb_vec_result_writer;

  localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef VWB_ADD_LANES_EN
  localparam int WORDS = 16;
`else
  localparam int WORDS = 12;
`endif

  logic         clk;
  logic         rst;
  logic         vec_alu_op;
  logic [255:0] res_mul;
  logic [127:0] res_sum;
  logic [127:0] res_add;
  logic         in_ready;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         done;
  logic         overflow;
  logic [7:0]   bundle_cnt;

  vec_result_writer #(.BASE_ADDR(BASE), .BCNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .vec_alu_op (vec_alu_op),
    .res_mul    (res_mul),
    .res_sum    (res_sum),
    .res_add    (res_add),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .done       (done),
    .overflow   (overflow),
    .bundle_cnt (bundle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane(input int p, input int b, input int k);
    return 32'(p * 256 + b + k);
  endfunction

  // Drive one bundle for one edge; when acceptance is expected, queue its words
  task automatic push_bundle(input int p, input logic exp_acc);
    exp_t e;
    for (int k = 0; k < 8; k++) res_mul[32*k +: 32] = lane(p, 1, k);
    for (int k = 0; k < 4; k++) res_sum[32*k +: 32] = lane(p, 16, k);
    for (int k = 0; k < 4; k++) res_add[32*k +: 32] = lane(p, 32, k);
    vec_alu_op = 1'b1;
    chk("in_ready_pre_push", 32'(in_ready), 32'(exp_acc));
    if (exp_acc) begin
      for (int i = 0; i < WORDS; i++) begin
        e.addr = BASE + 32'(4 * (((n_accepted % 256) * WORDS) + i));
        if (i < 8)       e.data = lane(p, 1, i);
        else if (i < 12) e.data = lane(p, 16, i - 8);
        else             e.data = lane(p, 32, i - 12);
        e.last = (i == WORDS - 1);
        q.push_back(e);
      end
      n_accepted++;
    end
    @(posedge clk); #1;
    vec_alu_op = 1'b0;
  endtask

  // Run with mem_ready low on cycles lo..hi (relative to now) until done; returns cycles used
  task automatic run_until_done(input int lo, input int hi, output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      mem_ready = !(c >= lo && c <= hi);
      @(negedge clk);
      cyc = c + 1;
      if (done) found = 1'b1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    chk("done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_we"},    32'(mem_we),     32'd0);
    chk({tag, "_done"},      32'(done),       32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),   32'd1);
    chk({tag, "_mem_addr"},  mem_addr,        BASE);
    chk({tag, "_mem_wdata"}, mem_wdata,       32'd0);
    chk({tag, "_bcnt"},      32'(bundle_cnt), 32'd0);
    chk({tag, "_overflow"},  32'(overflow),   32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vec_alu_op = 1'b0;
    @(posedge clk); #1;
    q.delete();
    n_accepted = 0;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compare every accepted word against the scoreboard and check stall stability
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic [31:0] prev_data  = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_data", mem_wdata, prev_data);
      end
      if (mem_we && mem_ready) begin
        if (q.size() == 0) begin
          chk("write_expected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_done", 32'(done), 32'(e.last));
        end
      end else begin
        chk("done_quiet", 32'(done), 32'd0);
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int cyc;
    rst = 1'b1;
    vec_alu_op = 1'b0;
    res_mul = '0;
    res_sum = '0;
    res_add = '0;
    mem_ready = 1'b1;
    do_reset();

    // Single bundle, memory always ready
    push_bundle(0, 1'b1);
    run_until_done(-1, -1, cyc);
    chk("single_cycles", 32'(cyc), 32'(WORDS));
    chk("single_bcnt", 32'(bundle_cnt), 32'd1);

    // Same bundle, memory stalls on cycles 3..5 holding word 3
    push_bundle(0, 1'b1);
    run_until_done(3, 5, cyc);
    chk("stall_cycles", 32'(cyc), 32'(WORDS + 3));
    chk("stall_bcnt", 32'(bundle_cnt), 32'd2);

    // Three bundles back to back while memory is stalled: the third is dropped
    do_reset();
    mem_ready = 1'b0;
    push_bundle(2, 1'b1);
    push_bundle(3, 1'b1);
    push_bundle(4, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_mem_we", 32'(mem_we), 32'd1);
    run_until_done(-1, -1, cyc);
    chk("full_first_cycles", 32'(cyc), 32'(WORDS));
    run_until_done(-1, -1, cyc);
    chk("full_second_cycles", 32'(cyc), 32'(WORDS));
    chk("full_bcnt", 32'(bundle_cnt), 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Push during the last word of the only entry
    push_bundle(5, 1'b1);
    repeat (WORDS - 1) begin
      @(posedge clk); #1;
    end
    push_bundle(6, 1'b1);
    chk("chain_mem_we", 32'(mem_we), 32'd1);
    chk("chain_in_ready", 32'(in_ready), 32'd1);
    run_until_done(-1, -1, cyc);
    chk("chain_cycles", 32'(cyc), 32'(WORDS));
    chk("chain_bcnt", 32'(bundle_cnt), 32'd4);

    // Reset in the middle of a bundle, with a bundle offered during reset
    push_bundle(7, 1'b1);
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_word7_addr", mem_addr, BASE + 32'(4 * (4 * WORDS + 7)));
    rst = 1'b1;
    vec_alu_op = 1'b1;
    @(posedge clk); #1;
    q.delete();
    n_accepted = 0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    vec_alu_op = 1'b0;
    @(posedge clk); #1;
    chk("midrst_op_ignored", 32'(mem_we), 32'd0);
    push_bundle(8, 1'b1);
    run_until_done(-1, -1, cyc);
    chk("midrst_cycles", 32'(cyc), 32'(WORDS));
    chk("midrst_bcnt", 32'(bundle_cnt), 32'd1);

    @(posedge clk); #1;
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
